// File: rtl/regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_sb                                                 |
// | Description : Register file with per-entry pending (scoreboard) bits,   |
// |               combinational multi-port reads and a registered count of   |
// |               pending entries.                                           |
// | Options     : define REGFILE_SB_BYPASS_EN for same-cycle write bypass    |
// |               onto the read ports.                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;
  logic              w_wr_ok;
  logic              w_iss_ok;

  // Writes and issues aimed at a hardwired-zero entry 0 are dropped here,
  // so entry 0 never gains data or a pending bit.
  assign w_wr_ok  = we        && !((ZERO_REG != 0) && (waddr    == '0));
  assign w_iss_ok = iss_valid && !((ZERO_REG != 0) && (iss_addr == '0));

  // Next pending vector: write-back clears, issue sets (wins a collision),
  // flush clears everything and beats both.
  always_comb begin
    pend_d = pend_q;
    if (w_wr_ok) begin
      pend_d[waddr] = 1'b0;
    end
    if (w_iss_ok) begin
      pend_d[iss_addr] = 1'b1;
    end
    if (flush) begin
      pend_d = '0;
    end
  end

  // Population count of the next pending vector, registered with it so the
  // count always agrees with the pending bits.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
    end
  end

  // Scoreboard state: pending bits and their count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Register storage; cleared by reset, written on write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign busy_cnt = cnt_q;

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_data;
      logic              w_busy;
      logic              w_is_zero;

      assign w_ra      = rd_addr[k*ADDR_W +: ADDR_W];
      assign w_is_zero = (ZERO_REG != 0) && (w_ra == '0);

      // Combinational read of the stored entry, optionally replaced by the
      // write-back in flight this cycle.
      always_comb begin
        w_data = mem_q[w_ra];
        w_busy = pend_q[w_ra];
`ifdef REGFILE_SB_BYPASS_EN
        if (w_wr_ok && (waddr == w_ra)) begin
          w_data = wdata;
          w_busy = w_iss_ok && (iss_addr == waddr);
        end
`else
`endif
        if (w_is_zero) begin
          w_data = '0;
          w_busy = 1'b0;
        end
      end

      assign rd_data[k*DATA_W +: DATA_W] = w_data;
      assign rd_busy[k]                  = w_busy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_regfile_sb                                              |
// | Description : Self-checking bench for regfile_sb against an array-based  |
// |               reference model; honours REGFILE_SB_BYPASS_EN.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     we = 1'b0;
  logic [ADDR_W-1:0]        waddr = '0;
  logic [DATA_W-1:0]        wdata = '0;
  logic                     iss_valid = 1'b0;
  logic [ADDR_W-1:0]        iss_addr = '0;
  logic                     flush = 1'b0;
  logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [ADDR_W:0]          busy_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] ref_mem  [DEPTH];
  bit                ref_pend [DEPTH];

  regfile_sb #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(1)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .flush    (flush),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (ref_pend[i]) c++;
    return c;
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]  = '0;
      ref_pend[i] = 1'b0;
    end
  endtask

  // Apply the architectural effect of the inputs present at a rising edge.
  task automatic model_edge();
    if (!rst_n) begin
      ref_clear();
    end else begin
      if (we && waddr != 0) begin
        ref_mem[waddr]  = wdata;
        ref_pend[waddr] = 1'b0;
      end
      if (iss_valid && iss_addr != 0) ref_pend[iss_addr] = 1'b1;
      if (flush) for (int i = 0; i < DEPTH; i++) ref_pend[i] = 1'b0;
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] ed;
    bit                eb;
    for (int k = 0; k < NUM_RD; k++) begin
      a  = rd_addr[k*ADDR_W +: ADDR_W];
      ed = ref_mem[a];
      eb = ref_pend[a];
`ifdef REGFILE_SB_BYPASS_EN
      if (rst_n && we && waddr == a && a != 0) begin
        ed = wdata;
        eb = iss_valid && (iss_addr == a);
      end
`endif
      chk_eq($sformatf("%s rd_data[%0d] (a=%0d)", ctx, k, a), 64'(rd_data[k*DATA_W +: DATA_W]), 64'(ed));
      chk_eq($sformatf("%s rd_busy[%0d] (a=%0d)", ctx, k, a), 64'(rd_busy[k]), 64'(eb));
    end
    chk_eq($sformatf("%s busy_cnt", ctx), 64'(busy_cnt), 64'(ref_count()));
  endtask

  // One clock: drive inputs, check combinational outputs mid-cycle, then
  // advance the model across the rising edge.
  task automatic cycle(input bit w, input int wa, input logic [31:0] wd,
                       input bit iv, input int ia, input bit fl,
                       input int r0, input int r1, input string ctx);
    we        = w;
    waddr     = ADDR_W'(wa);
    wdata     = wd;
    iss_valid = iv;
    iss_addr  = ADDR_W'(ia);
    flush     = fl;
    rd_addr   = {ADDR_W'(r1), ADDR_W'(r0)};
    #4;
    check_outputs(ctx);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle_read(input int r0, input int r1);
    we        = 1'b0;
    iss_valid = 1'b0;
    flush     = 1'b0;
    rd_addr   = {ADDR_W'(r1), ADDR_W'(r0)};
    #1;
  endtask

  initial begin
    int cnt_before;
    int wa;
    ref_clear();

    // Reset state
    @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;

    // Asynchronous reset clears a written entry without a clock
    cycle(1, 5, 32'h1234, 0, 0, 0, 5, 5, "write r5");
    set_idle_read(5, 5);
    chk_eq("r5 before reset", 64'(rd_data[31:0]), 64'h1234);
    rst_n = 1'b0;
    #1;
    chk_eq("r5 async reset data", 64'(rd_data[31:0]), 64'h0);
    chk_eq("r5 async reset busy", 64'(rd_busy), 64'h0);
    chk_eq("async reset busy_cnt", 64'(busy_cnt), 64'h0);
    ref_clear();
    cycle(1, 5, 32'h777, 1, 5, 0, 6, 7, "held reset");
    rst_n = 1'b1;
    set_idle_read(5, 5);
    chk_eq("reset overrides write", 64'(rd_data[31:0]), 64'h0);
    chk_eq("reset overrides issue", 64'(busy_cnt), 64'h0);

    // Scoreboard
    cycle(0, 0, 0, 1, 3, 0, 3, 7, "issue r3");
    cycle(0, 0, 0, 1, 7, 0, 3, 7, "issue r7");
    set_idle_read(3, 7);
    chk_eq("two pending busy_cnt", 64'(busy_cnt), 64'd2);
    chk_eq("two pending rd_busy", 64'(rd_busy), 64'b11);
    cycle(1, 3, 32'hDEADBEEF, 0, 0, 0, 3, 7, "wb r3");
    set_idle_read(3, 7);
    chk_eq("wb busy_cnt", 64'(busy_cnt), 64'd1);
    chk_eq("wb r3 busy", 64'(rd_busy[0]), 64'd0);
    chk_eq("wb r3 data", 64'(rd_data[31:0]), 64'hDEADBEEF);

    // Collision: issue wins over write-back
    cycle(0, 0, 0, 1, 9, 0, 9, 9, "issue r9");
    set_idle_read(9, 9);
    cnt_before = int'(busy_cnt);
    cycle(1, 9, 32'hA5A5A5A5, 1, 9, 0, 9, 1, "collide r9");
    set_idle_read(9, 9);
    chk_eq("collide r9 data", 64'(rd_data[31:0]), 64'hA5A5A5A5);
    chk_eq("collide r9 busy", 64'(rd_busy[0]), 64'd1);
    chk_eq("collide busy_cnt", 64'(busy_cnt), 64'(cnt_before));

    // Flush beats a simultaneous issue
    cycle(0, 0, 0, 1, 1, 0, 1, 2, "issue r1");
    cycle(0, 0, 0, 1, 2, 0, 1, 2, "issue r2");
    cycle(0, 0, 0, 1, 4, 0, 1, 4, "issue r4");
    cycle(0, 0, 0, 1, 6, 1, 6, 1, "flush+issue r6");
    set_idle_read(6, 4);
    chk_eq("flush busy_cnt", 64'(busy_cnt), 64'd0);
    chk_eq("flush rd_busy", 64'(rd_busy), 64'd0);

    // Hardwired zero register
    cycle(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, "zero reg");
    set_idle_read(0, 0);
    chk_eq("r0 data", 64'(rd_data), 64'h0);
    chk_eq("r0 busy", 64'(rd_busy), 64'h0);
    chk_eq("r0 busy_cnt", 64'(busy_cnt), 64'h0);

    // Bypass
    we = 1'b1; waddr = 5'd10; wdata = 32'h42; iss_valid = 1'b0; flush = 1'b0;
    rd_addr = {5'd10, 5'd0};
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    chk_eq("bypass same cycle", 64'(rd_data[63:32]), 64'h42);
`else
    chk_eq("no bypass old value", 64'(rd_data[63:32]), 64'h0);
`endif
    check_outputs("bypass cycle");
    @(posedge clk);
    model_edge();
    #1;
    set_idle_read(0, 10);
    chk_eq("r10 after edge", 64'(rd_data[63:32]), 64'h42);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      wa = int'($urandom_range(0, DEPTH - 1));
      cycle($urandom_range(0, 1) == 1, wa, $urandom,
            $urandom_range(0, 2) != 0,
            ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, DEPTH - 1)),
            $urandom_range(0, 15) == 0,
            ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, DEPTH - 1)),
            ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, DEPTH - 1)),
            $sformatf("rand%0d", n));
    end
    set_idle_read(0, 0);
    #2;
    check_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
